prog_frame_loader: RTL and testbench
====================================

// Module: prog_frame_loader
// PURPOSE
//  Front end of the scheduler. It receives a program as a 16-bit word stream from the host,
//  builds the DATA_DEPTH-word frame image, and checks the task layout. A task is one header
//  frame followed by if_num instruction frames.
//  On a clean load it drives the scheduler's prog_loading and data_frames_in, then pulses sched_reset.
//  It accepts a new load only while every core reports ready.
// PARAMETERS
//  DATA_DEPTH  1024  image depth in words (multiple of FRAME_WORDS)
//  INSTR_SIZE  16    word width
//  FRAME_WORDS 16    words per frame
//  CORE_NUM    16    number of cores
//  PROG_HOLD   2     cycles prog_loading is held high during commit (>=1)
// PORTS
//  clk           in   1                        clock
//  reset         in   1                        sync, active-high
//  load_req      in   1                        level; request a new program load
//  core_ready    in   CORE_NUM                 per-core idle flags (1 = idle)
//  host_valid    in   1                        stream word valid
//  host_data     in   INSTR_SIZE               stream word
//  host_last     in   1                        marks the final word of the program
//  host_ready    out  1                        loader accepts the word
//  prog_loading  out  1                        to scheduler; image copy enable
//  data_frames_out out DATA_DEPTH*INSTR_SIZE   image to scheduler data_frames_in; word j at [j*16+:16]
//  sched_reset   out  1                        one-cycle scheduler restart after commit
//  busy          out  1                        high in every state except IDLE
//  done          out  1                        one-cycle pulse on successful load
//  err           out  1                        sticky error flag
//  err_code      out  2                        01 overflow, 10 misaligned, 11 truncated task
// BEHAVIOUR
//  Reset values
//   - All outputs 0; image words all 0; FSM in IDLE; all counters 0.
//  FSM: IDLE -> RECV -> (COMMIT -> RESTART -> IDLE) | (DRAIN -> IDLE)
//  IDLE
//   - Leaves for RECV when load_req & (&core_ready).
//   - In that same cycle: image cleared to 0, err/err_code cleared, wr_ptr=0, remaining=0,
//     in_header=1.
//   - host_ready=0 while in IDLE.
//  RECV
//   - host_ready=1; a word is accepted on host_valid & host_ready.
//   - Accepted word is written to image[wr_ptr]; wr_ptr increments.
//   - Word at frame offset 0 of a header frame: remaining <= word & SCHED_IFNUM_MASK (bits[5:0]).
//   - At frame end (offset FRAME_WORDS-1):
//     - if in_header and remaining!=0: in_header <= 0;
//     - else if !in_header: remaining decrements; in_header returns to 1 when remaining reaches 0.
//   - Header with if_num=0 is a header-only task; the next frame is again a header.
//   - Error checks take priority over normal progress, in this order:
//     - overflow: word accepted with wr_ptr==DATA_DEPTH -> err_code 01; the word is not written.
//     - misaligned: host_last on a word whose offset != FRAME_WORDS-1 -> err_code 10.
//     - truncated: host_last at frame end while a task is still open
//       (!in_header after the update, or header just opened with remaining!=0) -> err_code 11.
//   - On error: err=1.
//     - If the erring word had host_last -> IDLE; otherwise -> DRAIN.
//   - Clean host_last -> COMMIT.
//  DRAIN
//   - host_ready=1; accepted words are discarded; exits to IDLE on an accepted word with host_last.
//   - prog_loading never rises after an error.
//  COMMIT
//   - prog_loading=1 for exactly PROG_HOLD cycles, then RESTART.
//   - data_frames_out is stable for the whole of COMMIT and after it.
//  RESTART
//   - sched_reset=1 for one cycle; done=1 in the following cycle, which is back in IDLE.
//  Latency and timing
//   - Last accepted word -> prog_loading high: 1 cycle.
//   - load_req is ignored outside IDLE.
//   - core_ready is sampled only at IDLE exit.
//  Reset mid-operation
//   - Immediate return to IDLE; image cleared; prog_loading/sched_reset drop in the same cycle
//     (synchronous reset).
//  Widths
//   - wr_ptr is $clog2(DATA_DEPTH)+1 bits so that DATA_DEPTH is representable; no wrap.
//   - remaining is 6 bits.
// STRUCTURE
//  - gpu_def.v holds SCHED_IFNUM_MASK and SCHED_FENCE_MASK, plus new LDR_ERR_OVF/MIS/TRN codes
//    and LDR_ST_* state encodings.
//  - One sub-module, ldr_task_parser: tracks frame offset, in_header and remaining.
//    It outputs frame_end, task_open and header_word strobes.
//  - The top level holds the FSM, the image and the error logic.
// TESTING
//  - Single task, header 0x0002, 48 words, host_last on word 47 ->
//    prog_loading high for 2 cycles, image[0]=0x0002, sched_reset then done, err=0.
//  - load_req with core_ready=0xFFFE -> stays IDLE with host_ready=0;
//    core_ready set to 0xFFFF -> RECV next cycle.
//  - host_last on word 20 -> err=1, err_code=10, IDLE, prog_loading never rises.
//  - Header 0x0003 followed by only 2 instruction frames and host_last -> err_code=11.
//  - 1025 words without host_last ->
//    err_code=01 at word 1025, DRAIN until host_last, image[1023] holds word 1024's data.
//  - reset during COMMIT -> prog_loading 0 next cycle, outputs 0, then a new full load succeeds.

Source files
------------

// File: rtl/prog_frame_loader_pkg.sv
// Shared definitions for the program frame loader: scheduler header masks,
// loader error codes and FSM state encodings.
package prog_frame_loader_pkg;

    localparam logic [15:0] SCHED_IFNUM_MASK = 16'h003F;
    localparam logic [15:0] SCHED_FENCE_MASK = 16'h0040;

    localparam logic [1:0] LDR_ERR_NONE = 2'b00;
    localparam logic [1:0] LDR_ERR_OVF  = 2'b01;
    localparam logic [1:0] LDR_ERR_MIS  = 2'b10;
    localparam logic [1:0] LDR_ERR_TRN  = 2'b11;

    typedef enum logic [2:0] {
        LDR_ST_IDLE    = 3'd0,
        LDR_ST_RECV    = 3'd1,
        LDR_ST_COMMIT  = 3'd2,
        LDR_ST_RESTART = 3'd3,
        LDR_ST_DRAIN   = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/ldr_task_parser.sv
// Tracks the frame offset and the header/instruction-frame structure of the
// incoming program, and reports whether a task is still open after each word.
module ldr_task_parser #(
    parameter int FRAME_WORDS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       accept,
    input  logic [5:0] if_num,
    output logic       frame_end,
    output logic       header_word,
    output logic       task_open
);
    localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_WORDS - 1);

    logic [OFF_W-1:0] offset;
    logic             in_header;
    logic [5:0]       remaining;
    logic [5:0]       rem_eff;
    logic [5:0]       rem_next;
    logic             in_header_next;

    assign frame_end   = (offset == LAST_OFF);
    assign header_word = in_header && (offset == '0);

    // The header count takes effect on its own word, so a one-word frame still works.
    always_comb begin
        rem_eff        = header_word ? if_num : remaining;
        rem_next       = rem_eff;
        in_header_next = in_header;
        if (frame_end) begin
            if (in_header && (rem_eff != 6'd0)) begin
                in_header_next = 1'b0;
            end else if (!in_header) begin
                rem_next       = rem_eff - 6'd1;
                in_header_next = (rem_eff == 6'd1);
            end
        end
    end

    assign task_open = !in_header_next;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            offset    <= '0;
            in_header <= 1'b1;
            remaining <= 6'd0;
        end else if (accept) begin
            offset    <= frame_end ? '0 : offset + OFF_W'(1);
            in_header <= in_header_next;
            remaining <= rem_next;
        end
    end

endmodule

// File: rtl/prog_frame_loader.sv
// Scheduler front end: receives the host program stream into the frame image,
// validates the task layout and, on a clean load, commits and restarts the scheduler.
module prog_frame_loader
    import prog_frame_loader_pkg::*;
#(
    parameter int DATA_DEPTH  = 1024,
    parameter int INSTR_SIZE  = 16,
    parameter int FRAME_WORDS = 16,
    parameter int CORE_NUM    = 16,
    parameter int PROG_HOLD   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_req,
    input  logic [CORE_NUM-1:0]             core_ready,
    input  logic                            host_valid,
    input  logic [INSTR_SIZE-1:0]           host_data,
    input  logic                            host_last,
    output logic                            host_ready,
    output logic                            prog_loading,
    output logic [DATA_DEPTH*INSTR_SIZE-1:0] data_frames_out,
    output logic                            sched_reset,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [1:0]                      err_code
);
    localparam int ADDR_W = $clog2(DATA_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(PROG_HOLD + 1);
    localparam logic [PTR_W-1:0]  PTR_FULL  = PTR_W'(DATA_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PROG_HOLD - 1);

    ldr_state_e                            state;
    logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] image;
    logic [PTR_W-1:0]                      wr_ptr;
    logic [HOLD_W-1:0]                     hold_cnt;

    logic       start;
    logic       accept;
    logic       ovf;
    logic       frame_end;
    logic       header_word;
    logic       task_open;
    logic [5:0] if_num;
    logic [1:0] err_sel;

    assign data_frames_out = image;

    // host_ready is registered high exactly in RECV and DRAIN, so accept implies one of them.
    assign start  = (state == LDR_ST_IDLE) && load_req && (&core_ready);
    assign accept = host_valid && host_ready;
    assign ovf    = (wr_ptr == PTR_FULL);
    assign if_num = header_word ? 6'(host_data & SCHED_IFNUM_MASK) : 6'd0;

    ldr_task_parser #(
        .FRAME_WORDS(FRAME_WORDS)
    ) u_parser (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .accept     (accept && (state == LDR_ST_RECV)),
        .if_num     (if_num),
        .frame_end  (frame_end),
        .header_word(header_word),
        .task_open  (task_open)
    );

    always_comb begin
        err_sel = LDR_ERR_NONE;
        if (ovf) begin
            err_sel = LDR_ERR_OVF;
        end else if (host_last && !frame_end) begin
            err_sel = LDR_ERR_MIS;
        end else if (host_last && task_open) begin
            err_sel = LDR_ERR_TRN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LDR_ST_IDLE;
            image        <= '0;
            wr_ptr       <= '0;
            hold_cnt     <= '0;
            host_ready   <= 1'b0;
            prog_loading <= 1'b0;
            sched_reset  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= LDR_ERR_NONE;
        end else begin
            done        <= 1'b0;
            sched_reset <= 1'b0;
            case (state)
                LDR_ST_IDLE: begin
                    if (start) begin
                        state      <= LDR_ST_RECV;
                        image      <= '0;
                        wr_ptr     <= '0;
                        err        <= 1'b0;
                        err_code   <= LDR_ERR_NONE;
                        host_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LDR_ST_RECV: begin
                    if (accept) begin
                        if (!ovf) begin
                            image[wr_ptr[ADDR_W-1:0]] <= host_data;
                            wr_ptr                    <= wr_ptr + PTR_W'(1);
                        end
                        if (err_sel != LDR_ERR_NONE) begin
                            err      <= 1'b1;
                            err_code <= err_sel;
                            if (host_last) begin
                                state      <= LDR_ST_IDLE;
                                host_ready <= 1'b0;
                                busy       <= 1'b0;
                            end else begin
                                state <= LDR_ST_DRAIN;
                            end
                        end else if (host_last) begin
                            state        <= LDR_ST_COMMIT;
                            host_ready   <= 1'b0;
                            prog_loading <= 1'b1;
                            hold_cnt     <= '0;
                        end
                    end
                end
                LDR_ST_DRAIN: begin
                    if (accept && host_last) begin
                        state      <= LDR_ST_IDLE;
                        host_ready <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                LDR_ST_COMMIT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state        <= LDR_ST_RESTART;
                        prog_loading <= 1'b0;
                        sched_reset  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                LDR_ST_RESTART: begin
                    state <= LDR_ST_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= LDR_ST_IDLE;
                    host_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_frame_loader.sv
// Directed bench for prog_frame_loader: clean loads, core gating, the three
// error classes, overflow drain and reset during commit.
`timescale 1ns/1ps
module tb_prog_frame_loader;
    localparam int DD = 1024;
    localparam int IS = 16;
    localparam int CN = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic [CN-1:0]     core_ready;
    logic              host_valid;
    logic [IS-1:0]     host_data;
    logic              host_last;
    logic              host_ready;
    logic              prog_loading;
    logic [DD*IS-1:0]  data_frames_out;
    logic              sched_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    int   n_tests;
    int   n_fail;
    logic prog_seen;
    logic [DD*IS-1:0] snap;

    prog_frame_loader #(
        .DATA_DEPTH (DD),
        .INSTR_SIZE (IS),
        .FRAME_WORDS(16),
        .CORE_NUM   (CN),
        .PROG_HOLD  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_req       (load_req),
        .core_ready     (core_ready),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_last      (host_last),
        .host_ready     (host_ready),
        .prog_loading   (prog_loading),
        .data_frames_out(data_frames_out),
        .sched_reset    (sched_reset),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_loading) prog_seen = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] img(input int j);
        return data_frames_out[j*IS +: IS];
    endfunction

    task automatic start_load();
        load_req   = 1'b1;
        core_ready = '1;
        tick();
        load_req = 1'b0;
        check("start_host_ready", 32'(host_ready), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] data, input logic last);
        host_valid = 1'b1;
        host_data  = data;
        host_last  = last;
        if (!host_ready) check("send_host_ready", 32'(host_ready), 32'd1);
        tick();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    // word 0 = hdr0, word hdr1_idx = hdr1, others base+i; last on last_idx (-1 = none)
    task automatic send_stream(input int n, input int last_idx, input logic [15:0] base,
                               input logic [15:0] hdr0, input int hdr1_idx, input logic [15:0] hdr1);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            if (i == 0) w = hdr0;
            else if (i == hdr1_idx) w = hdr1;
            else w = base + 16'(i);
            send_word(w, (i == last_idx));
        end
    endtask

    task automatic check_commit(input string tag);
        check({tag, "_prog_c0"}, 32'(prog_loading), 32'd1);
        snap = data_frames_out;
        tick();
        check({tag, "_prog_c1"}, 32'(prog_loading), 32'd1);
        check({tag, "_image_stable"}, 32'(data_frames_out === snap), 32'd1);
        tick();
        check({tag, "_prog_c2"}, 32'(prog_loading), 32'd0);
        check({tag, "_sched_reset"}, 32'(sched_reset), 32'd1);
        tick();
        check({tag, "_sched_drop"}, 32'(sched_reset), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prog_seen  = 1'b0;
        reset      = 1'b1;
        load_req   = 1'b0;
        core_ready = '0;
        host_valid = 1'b0;
        host_data  = '0;
        host_last  = 1'b0;
        tick();
        tick();
        check("rst_outputs", {26'd0, host_ready, prog_loading, sched_reset, busy, done, err}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_image_zero", 32'(data_frames_out == '0), 32'd1);
        reset = 1'b0;
        tick();

        // One core busy blocks the load; all ready moves to RECV on the next edge.
        load_req   = 1'b1;
        core_ready = 16'hFFFE;
        repeat (3) tick();
        check("gate_host_ready", 32'(host_ready), 32'd0);
        check("gate_busy", 32'(busy), 32'd0);
        core_ready = 16'hFFFF;
        tick();
        load_req = 1'b0;
        check("gate_open_host_ready", 32'(host_ready), 32'd1);
        check("gate_open_busy", 32'(busy), 32'd1);

        // Single task: header 0x0002 + two instruction frames.
        send_stream(48, 47, 16'hA000, 16'h0002, -1, 16'h0);
        check("clean_image0", 32'(img(0)), 32'h0002);
        check("clean_image47", 32'(img(47)), 32'hA02F);
        check("clean_image48", 32'(img(48)), 32'h0000);
        check_commit("clean");

        // Misaligned host_last on word 20.
        prog_seen = 1'b0;
        start_load();
        send_stream(21, 20, 16'hB000, 16'h0001, -1, 16'h0);
        check("mis_err", 32'(err), 32'd1);
        check("mis_code", 32'(err_code), 32'd2);
        check("mis_idle_busy", 32'(busy), 32'd0);
        check("mis_host_ready", 32'(host_ready), 32'd0);
        repeat (3) tick();
        check("mis_no_prog", 32'(prog_seen), 32'd0);

        // Truncated task: header 0x0003 with only two instruction frames.
        start_load();
        check("trn_err_cleared", 32'(err), 32'd0);
        send_stream(48, 47, 16'hC000, 16'h0003, -1, 16'h0);
        check("trn_err", 32'(err), 32'd1);
        check("trn_code", 32'(err_code), 32'd3);
        check("trn_idle_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("trn_no_prog", 32'(prog_seen), 32'd0);

        // Header-only task followed by a one-instruction task is a clean layout.
        start_load();
        send_stream(48, 47, 16'hE000, 16'h0000, 16, 16'h0001);
        check("hdr0_image16", 32'(img(16)), 32'h0001);
        check_commit("hdr0");

        // Overflow: 1025 words, no host_last, then drain.
        prog_seen = 1'b0;
        start_load();
        send_stream(1025, -1, 16'h1000, 16'h0002, -1, 16'h0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_code", 32'(err_code), 32'd1);
        check("ovf_drain_busy", 32'(busy), 32'd1);
        check("ovf_drain_ready", 32'(host_ready), 32'd1);
        check("ovf_image1023", 32'(img(1023)), 32'h13FF);
        send_word(16'hFFFF, 1'b0);
        send_word(16'hEEEE, 1'b0);
        check("ovf_still_drain", 32'(busy), 32'd1);
        send_word(16'hDDDD, 1'b1);
        check("ovf_exit_busy", 32'(busy), 32'd0);
        check("ovf_exit_ready", 32'(host_ready), 32'd0);
        check("ovf_code_sticky", 32'(err_code), 32'd1);
        check("ovf_image1023_kept", 32'(img(1023)), 32'h13FF);
        check("ovf_no_prog", 32'(prog_seen), 32'd0);

        // Reset in COMMIT, then a fresh full load.
        start_load();
        send_stream(16, 15, 16'hD000, 16'h0000, -1, 16'h0);
        check("rc_prog_up", 32'(prog_loading), 32'd1);
        reset = 1'b1;
        tick();
        check("rc_outputs", {26'd0, host_ready, prog_loading, sched_reset, busy, done, err}, 32'd0);
        check("rc_image_zero", 32'(data_frames_out == '0), 32'd1);
        reset = 1'b0;
        tick();
        check("rc_no_sched_reset", 32'(sched_reset), 32'd0);
        start_load();
        send_stream(48, 47, 16'hA000, 16'h0002, -1, 16'h0);
        check("rc_image0", 32'(img(0)), 32'h0002);
        check("rc_image47", 32'(img(47)), 32'hA02F);
        check_commit("rc_reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
